hash_mem_responder: RTL

- Synthesizable responder for the bitcoin_hash memory interface.
- Serves mem_addr/mem_we/mem_write_data accesses from the hash core and returns mem_read_data.
- Self-generates the 19-word block header from a seed, tracks nonce-result writes into the output window, and exposes a read-only host port for result readback.
- Sits beside bitcoin_hash at top level. The core's mem_clk is tied to the same clk.

---
 rtl/hash_mem_responder_if.sv | 28 ++
 rtl/hash_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_mem_responder_if.sv
// Purpose: core (port A) and host (port B) access bus of hash_mem_responder.
// Latency: n/a, this is only a signal bundle.
// Backpressure: none; both ports are always ready.
//
// master: hash core and host side, drives the requests.
// slave : hash_mem_responder, returns the read data.
interface hash_mem_responder_if;
    // Core port (port A)
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    // Host port (port B), read-only
    logic        host_re;
    logic [15:0] host_addr;
    logic [31:0] host_rdata;
    logic        host_rvalid;

    modport master (
        output mem_we, mem_addr, mem_write_data, host_re, host_addr,
        input  mem_read_data, host_rdata, host_rvalid
    );

    modport slave (
        input  mem_we, mem_addr, mem_write_data, host_re, host_addr,
        output mem_read_data, host_rdata, host_rvalid
    );
endinterface

// File: rtl/hash_mem_responder.sv
// Purpose: word memory for bitcoin_hash with header generator, result tracking and host readback.
// Latency: core and host reads return data 1 cycle after the request edge.
// Backpressure: none; every access completes in its cycle (core writes during header generation are dropped).
//
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   seed_load/seed/msg_base/out_base
//                                 start header generation, header seed and bases
//   init_busy, init_done          header generation status
//   bus (slave)                   core port mem_we/mem_addr/mem_write_data/mem_read_data
//                                 host port host_re/host_addr/host_rdata/host_rvalid
//   wr_count, all_written         in-window result write tracking
//   oob_err, busy_err, dup_err    sticky error flags
//
// Optional feature macro: HASH_MEM_WRCHK_EN
//   defined   : per-slot written bitmap; repeat writes to a slot set dup_err and do not count.
//   undefined : every in-window write counts (saturating); dup_err is tied 0.
module hash_mem_responder #(
    parameter int DEPTH      = 2048,
    parameter int HDR_WORDS  = 19,
    parameter int NUM_NONCES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    input  logic [15:0]          msg_base,
    input  logic [15:0]          out_base,
    output logic                 init_busy,
    output logic                 init_done,
    hash_mem_responder_if.slave  bus,
    output logic [7:0]           wr_count,
    output logic                 all_written,
    output logic                 oob_err,
    output logic                 busy_err,
    output logic                 dup_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(HDR_WORDS + 1);
    localparam int SW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

    localparam logic [16:0]   DEPTH17  = 17'(DEPTH);
    localparam logic [16:0]   NN17     = 17'(NUM_NONCES);
    localparam logic [7:0]    NN8      = 8'(NUM_NONCES);
    localparam logic [GW-1:0] GEN_LAST = GW'(HDR_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   mem [DEPTH];

    logic [15:0]   msg_base_q;
    logic [15:0]   out_base_q;
    logic [31:0]   gen_word_q;
    logic [GW-1:0] gen_idx_q;
    logic [7:0]    wr_count_q;
    logic          oob_err_q;
    logic          busy_err_q;
    logic [31:0]   mem_read_data_q;
    logic [31:0]   host_rdata_q;
    logic          host_rvalid_q;

    logic          in_gen;
    logic          start;
    logic          gen_last;
    logic [16:0]   gen_addr;
    logic          gen_in_range;
    logic          core_in_range;
    logic          host_in_range;
    logic [16:0]   win_lo;
    logic [16:0]   win_hi;
    logic [16:0]   core_addr17;
    logic          in_win;
    logic          win_wr;
    logic          slot_dup;

    logic          mem_wen;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdat;

    // ------------------------------------------------------------------
    // Address decode. Everything is widened to 17 bits so base+offset
    // cannot wrap past 0xFFFF back into low memory.
    // ------------------------------------------------------------------
    assign in_gen        = (state_q == GEN);
    assign start         = seed_load && !in_gen;
    assign gen_last      = (gen_idx_q == GEN_LAST);

    assign gen_addr      = {1'b0, msg_base_q} + 17'(gen_idx_q);
    assign gen_in_range  = (gen_addr < DEPTH17);
    assign core_in_range = ({1'b0, bus.mem_addr} < DEPTH17);
    assign host_in_range = ({1'b0, bus.host_addr} < DEPTH17);

    assign win_lo        = {1'b0, out_base_q};
    assign win_hi        = win_lo + NN17;
    assign core_addr17   = {1'b0, bus.mem_addr};
    assign in_win        = (core_addr17 >= win_lo) && (core_addr17 < win_hi);
    // Only writes that actually land in the array are counted as results.
    assign win_wr        = !in_gen && bus.mem_we && core_in_range && in_win;

    // ------------------------------------------------------------------
    // Init FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (seed_load) state_d = GEN;
            GEN:     if (gen_last)  state_d = DONE;
            DONE:    if (seed_load) state_d = GEN;
            default: state_d = IDLE;
        endcase
    end

    assign init_busy = in_gen;
    assign init_done = (state_q == DONE);

    // ------------------------------------------------------------------
    // Single write port: the header generator owns it during GEN,
    // otherwise the core does.
    // ------------------------------------------------------------------
    always_comb begin
        mem_wen  = 1'b0;
        mem_widx = '0;
        mem_wdat = '0;
        if (in_gen) begin
            mem_wen  = gen_in_range;
            mem_widx = gen_addr[AW-1:0];
            mem_wdat = gen_word_q;
        end else begin
            mem_wen  = bus.mem_we && core_in_range;
            mem_widx = bus.mem_addr[AW-1:0];
            mem_wdat = bus.mem_write_data;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Both sample the array before this edge's write lands,
    // so a same-cycle host read of a written word returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_data_q <= '0;
            host_rdata_q    <= '0;
            host_rvalid_q   <= 1'b0;
        end else begin
            // Write cycles leave the last read value in place.
            if (!bus.mem_we) begin
                if (in_gen || !core_in_range) begin
                    mem_read_data_q <= '0;
                end else begin
                    mem_read_data_q <= mem[bus.mem_addr[AW-1:0]];
                end
            end
            host_rvalid_q <= bus.host_re;
            if (bus.host_re) begin
                host_rdata_q <= host_in_range ? mem[bus.host_addr[AW-1:0]] : 32'd0;
            end
        end
    end

    assign bus.mem_read_data = mem_read_data_q;
    assign bus.host_rdata    = host_rdata_q;
    assign bus.host_rvalid   = host_rvalid_q;

    // ------------------------------------------------------------------
    // Header sequencer and result counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_base_q <= '0;
            out_base_q <= '0;
            gen_word_q <= '0;
            gen_idx_q  <= '0;
            wr_count_q <= '0;
        end else if (start) begin
            msg_base_q <= msg_base;
            out_base_q <= out_base;
            gen_word_q <= seed;
            gen_idx_q  <= '0;
            wr_count_q <= '0;
        end else if (in_gen) begin
            gen_word_q <= {gen_word_q[30:0], gen_word_q[31]};
            gen_idx_q  <= gen_idx_q + GW'(1);
        end else if (win_wr && !slot_dup && (wr_count_q != NN8)) begin
            wr_count_q <= wr_count_q + 8'd1;
        end
    end

    assign wr_count    = wr_count_q;
    assign all_written = (wr_count_q == NN8);

    // Sticky errors survive seed_load; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_err_q  <= 1'b0;
            busy_err_q <= 1'b0;
        end else begin
            if (!in_gen && !core_in_range) begin
                oob_err_q <= 1'b1;
            end
            if (in_gen && bus.mem_we) begin
                busy_err_q <= 1'b1;
            end
        end
    end

    assign oob_err  = oob_err_q;
    assign busy_err = busy_err_q;

`ifdef HASH_MEM_WRCHK_EN
    logic [NUM_NONCES-1:0] slots_q;
    logic [SW-1:0]         slot;
    logic                  dup_err_q;

    // addr - out_base is below NUM_NONCES whenever in_win holds, so the
    // low SW bits of the difference are exact.
    assign slot     = bus.mem_addr[SW-1:0] - out_base_q[SW-1:0];
    assign slot_dup = slots_q[slot];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots_q   <= '0;
            dup_err_q <= 1'b0;
        end else if (start) begin
            slots_q <= '0;
        end else if (win_wr) begin
            if (slot_dup) begin
                dup_err_q <= 1'b1;
            end else begin
                slots_q[slot] <= 1'b1;
            end
        end
    end

    assign dup_err = dup_err_q;
`else
    assign slot_dup = 1'b0;
    assign dup_err  = 1'b0;
`endif

endmodule
